// File: rtl/adder_pkg.sv
// Shared types and helpers for the chunked adder.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the slice index counter; at least one bit even for a single slice.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/chunk_add.sv
// Combinational W-bit ripple adder slice with carry into its top bit exposed.
module chunk_add #(
    parameter int W = 4
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co,
    output logic         c_msb
);

    logic [W:0] c;

    // Bit-serial carry ripple across the slice.
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < W; i++) begin
            s[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (x[i] & c[i]) | (y[i] & c[i]);
        end
        co    = c[W];
        c_msb = c[W-1];
    end

endmodule

// File: rtl/chunked_adder.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per clock, carry held between slices.
module chunked_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = idx_w(NCHUNK);

    state_t           state, state_nxt;
    logic [IW-1:0]    idx;
    logic             carry;
    logic [WIDTH-1:0] a_q, b_q, part, part_nxt;
    logic [CHUNK-1:0] x, y, s;
    logic             co, c_msb;
    logic             accept, last;

    chunk_add #(.W(CHUNK)) u_slice (
        .x     (x),
        .y     (y),
        .ci    (carry),
        .s     (s),
        .co    (co),
        .c_msb (c_msb)
    );

    // Slice selection, accept/last decode and partial-sum merge.
    always_comb begin
        x        = a_q[int'(idx)*CHUNK +: CHUNK];
        y        = b_q[int'(idx)*CHUNK +: CHUNK];
        last     = (idx == IW'(NCHUNK - 1));
        accept   = start && (state != RUN);
        part_nxt = part;
        part_nxt[int'(idx)*CHUNK +: CHUNK] = s;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and status outputs; a start in DONE chains straight into RUN.
    always_comb begin
        state_nxt = state;
        busy      = (state == RUN);
        done      = (state == DONE);
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (last)   state_nxt = DONE;
            DONE:    state_nxt = accept ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, slice accumulation and result update on the final slice.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx   <= '0;
            carry <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            part  <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            // Subtract is a + ~b + 1; cin is not used in that mode.
            a_q   <= a;
            b_q   <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            idx   <= '0;
        end else if (state == RUN) begin
            part  <= part_nxt;
            carry <= co;
            if (last) begin
                sum  <= part_nxt;
                cout <= co;
                ovf  <= c_msb ^ co;
            end else begin
                idx <= idx + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_chunked_adder.sv
// Self-checking bench: three chunk sizes driven in parallel against an arithmetic model.
module tb_chunked_adder;

    logic        clk = 1'b0;
    logic        rst_n, start, cin, sub;
    logic [15:0] a, b;

    logic        busy4, done4, cout4, ovf4;
    logic        busy1, done1, cout1, ovf1;
    logic        busy16, done16, cout16, ovf16;
    logic [15:0] sum4, sum1, sum16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    chunked_adder #(.WIDTH(16), .CHUNK(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4));

    chunked_adder #(.WIDTH(16), .CHUNK(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1));

    chunked_adder #(.WIDTH(16), .CHUNK(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: {ovf, cout, sum} from two's-complement arithmetic and the sign rule.
    function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic mcin, input logic msub);
        logic [15:0] bb;
        logic [16:0] t;
        logic        ov;
        bb = msub ? ~mb : mb;
        t  = {1'b0, ma} + {1'b0, bb} + 17'(msub ? 1'b1 : mcin);
        ov = (ma[15] == bb[15]) && (t[15] != ma[15]);
        return {ov, t};
    endfunction

    task automatic check_res(input string tag, input logic [17:0] e,
                             input logic [15:0] s, input logic c, input logic o,
                             input int lat, input int exp_lat, input int pulses);
        check($sformatf("%s sum", tag),    32'(s),      32'(e[15:0]));
        check($sformatf("%s cout", tag),   32'(c),      32'(e[16]));
        check($sformatf("%s ovf", tag),    32'(o),      32'(e[17]));
        check($sformatf("%s latency", tag), 32'(lat),   32'(exp_lat));
        check($sformatf("%s pulses", tag), 32'(pulses), 32'd1);
    endtask

    task automatic do_op(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                         input logic tcin, input logic tsub);
        logic [17:0] e;
        int          edges;
        int          lat[3];
        int          pul[3];
        e = model(ta, tb, tcin, tsub);
        for (int i = 0; i < 3; i++) begin
            lat[i] = 0;
            pul[i] = 0;
        end
        @(negedge clk);
        a = ta; b = tb; cin = tcin; sub = tsub; start = 1'b1;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        check($sformatf("%s busy4", tag), 32'(busy4), 32'd1);
        for (int k = 0; k < 22; k++) begin
            if (done4)  begin pul[0]++; if (lat[0] == 0) lat[0] = edges; end
            if (done1)  begin pul[1]++; if (lat[1] == 0) lat[1] = edges; end
            if (done16) begin pul[2]++; if (lat[2] == 0) lat[2] = edges; end
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check_res({tag, "/c4"},  e, sum4,  cout4,  ovf4,  lat[0], 5,  pul[0]);
        check_res({tag, "/c1"},  e, sum1,  cout1,  ovf1,  lat[1], 17, pul[1]);
        check_res({tag, "/c16"}, e, sum16, cout16, ovf16, lat[2], 2,  pul[2]);
    endtask

    initial begin
        int          edges, n, d1, d2;
        logic [15:0] s1, s2;

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy",  32'(busy4 | busy1 | busy16), 32'd0);
        check("reset done",  32'(done4 | done1 | done16), 32'd0);
        check("reset sum",   32'(sum4 | sum1 | sum16),    32'd0);
        check("reset flags", 32'({cout4, ovf4, cout1, ovf1, cout16, ovf16}), 32'd0);
        rst_n = 1'b1;

        do_op("add7+2",    16'h0007, 16'h0002, 1'b0, 1'b0);
        do_op("ripple",    16'hFFFF, 16'h0001, 1'b0, 1'b0);
        do_op("posovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0);
        do_op("subovf",    16'h8000, 16'h0001, 1'b0, 1'b1);
        do_op("subcin",    16'h0002, 16'h0002, 1'b1, 1'b1);
        do_op("cin",       16'h00FF, 16'h0000, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++)
            do_op($sformatf("rnd%0d", i), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));

        // Restart during RUN is ignored; start held in DONE chains the next op.
        @(negedge clk);
        a = 16'h0009; b = 16'h0005; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk); edges = 1;
        @(negedge clk); start = 1'b0;
        @(posedge clk); edges = 2;
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; start = 1'b1;
        n = 0; d1 = 0; d2 = 0; s1 = '0; s2 = '0;
        for (int k = 0; k < 20; k++) begin
            if (edges == 6) start = 1'b0;
            if (done4) begin
                if (n == 0) begin d1 = edges; s1 = sum4; end
                else if (n == 1) begin d2 = edges; s2 = sum4; end
                n++;
            end
            @(posedge clk); edges++;
            @(negedge clk);
        end
        check("restart first sum",   32'(s1), 32'h000E);
        check("restart first time",  32'(d1), 32'd5);
        check("chain second sum",    32'(s2), 32'h3333);
        check("chain spacing",       32'(d2 - d1), 32'd5);
        check("chain pulses",        32'(n), 32'd2);
        repeat (20) @(negedge clk);

        // Reset at E2 of an operation, with start also high on that edge.
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        @(posedge clk);
        @(negedge clk); rst_n = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("midrun busy", 32'({busy4, busy1, busy16}), 32'd0);
        check("midrun done", 32'({done4, done1, done16}), 32'd0);
        check("midrun sum",  32'(sum4 | sum1 | sum16), 32'd0);
        check("midrun flags", 32'({cout4, ovf4, cout1, ovf1, cout16, ovf16}), 32'd0);
        rst_n = 1'b1;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            if (done4 | done1 | done16) n++;
            @(negedge clk);
        end
        check("midrun no done", 32'(n), 32'd0);
        do_op("after_reset", 16'hABCD, 16'h1357, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/chunked_adder.md
# chunked_adder

Parametrised multi-cycle adder/subtractor. It processes a WIDTH-bit addition in CHUNK-bit slices, one slice per clock, with the carry held in a register between slices. A start/busy/done handshake controls each operation. It succeeds the fixed 4-bit combinational adder and trades latency for a short carry chain at wide widths. It adds a subtract mode and signed-overflow reporting.

## Interface
- WIDTH, 16: operand/result width; must be a multiple of CHUNK.
- CHUNK, 4: bits added per cycle; 1 ≤ CHUNK ≤ WIDTH.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; synchronous and active-low.
- start  in  1  request; sampled only when the block can accept (see Operation).
- a  in  WIDTH  operand A; sampled with start.
- b  in  WIDTH  operand B; sampled with start.
- cin  in  1  carry-in; sampled with start; ignored when sub=1.
- sub  in  1  mode; 0: a+b+cin, 1: a−b (computed as a + ~b + 1).
- busy  out  1  high while slices are being processed.
- done  out  1  one-cycle pulse; result valid.
- sum  out  WIDTH  result; holds last completed result.
- cout  out  1  carry out of the MSB; for subtract, 1 means no borrow.
- ovf  out  1  signed overflow = carry into MSB XOR carry out of MSB.

## Operation
- NCHUNK = WIDTH/CHUNK; idx counter width = max(1, clog2(NCHUNK)).
- States: IDLE, RUN, DONE.
- Accepting a request:
  - start is accepted in IDLE or DONE; ignored in RUN.
  - On accept: latch a, and b (or ~b when sub=1).
  - Carry reg = sub ? 1 : cin; idx=0; go to RUN.
- RUN, each edge:
  - {c, s} = a[idx*CHUNK +: CHUNK] + b'[idx*CHUNK +: CHUNK] + carry.
  - s is written to the partial-sum reg slice idx; carry ← c; idx++.
- At slice NCHUNK−1:
  - Copy the partial sum to sum; set cout = c.
  - Set ovf = (carry into bit WIDTH−1) ^ c; go to DONE.
- DONE: done=1 for this one cycle. Without an accepted start, go to IDLE.
- Output timing: sum/cout/ovf change only on the completing edge; they never show partial results.
- busy = (state==RUN). done = (state==DONE).
- Operands may change freely after the accepting edge.

## Timing
- Reset (rst_n=0 at an edge):
  - State IDLE; busy=0, done=0, sum=0, cout=0, ovf=0.
  - idx, carry and partial reg are cleared.
- Reset mid-RUN aborts the operation: no done pulse, outputs go to 0.
- Latency:
  - Accept at edge E0. Slices processed at E1..E_NCHUNK.
  - done is high in the cycle after E_NCHUNK; start-to-done = NCHUNK+1 edges.
- Throughput: start held high in DONE gives one result every NCHUNK+1 cycles.
- start and rst_n low on the same edge: reset wins.
- CHUNK=WIDTH: single RUN cycle. CHUNK=1: WIDTH RUN cycles.

## Structure
- Package adder_pkg:
  - state enum (IDLE, RUN, DONE).
  - Helper function for the idx width.
- Sub-module chunk_add, combinational:
  - CHUNK-bit ripple adder; inputs x, y, ci.
  - Outputs s, co and c_msb (carry into its top bit).
  - The top chunk's c_msb feeds the ovf computation.
- Top module: FSM, idx counter, operand/partial/result registers.

## Test plan
- WIDTH=16, CHUNK=4; a=0x0007, b=0x0002, cin=0, start at E0.
  - busy during E1..E4; done in the cycle after E4.
  - sum=0x0009, cout=0, ovf=0.
- a=0xFFFF, b=0x0001, cin=0 (carry ripples through every slice) → sum=0x0000, cout=1, ovf=0.
- a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, ovf=1.
- sub=1, a=0x8000, b=0x0001 → sum=0x7FFF, cout=1, ovf=1.
- sub=1, a=0x0002, b=0x0002, cin=1 (cin ignored) → sum=0x0000, cout=1.
- start re-asserted with a=0x1111, b=0x2222 during RUN of (0x0009+0x0005):
  - The re-start is ignored; result is 0x000E.
  - Holding start high in DONE accepts the next op; next result 0x3333 arrives NCHUNK+1 cycles later.
- rst_n low at E2 of an operation:
  - No done pulse; all outputs 0 the next cycle.
  - A fresh start afterwards completes correctly.
- Repeat the arithmetic cases at CHUNK=1 and CHUNK=16: identical results; latency 17 and 2 edges respectively.
